// File: rtl/ps2_keydecode.sv
// PS/2 Set-2 scan-code decoder: folds E0/F0 prefixes into one make/break event
// per key and keeps a pressed-state bitmap of the game control keys.
module ps2_keydecode #(
  parameter int PREFIX_TIMEOUT = 100000,
  parameter int TO_W           = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ps2_data,
  input  logic       ps2_ready,
  output logic       key_event,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic [6:0] key_state
);

  typedef enum logic [1:0] {S_IDLE, S_E0, S_F0, S_E0F0} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(PREFIX_TIMEOUT - 1);

  state_t          state_reg, state_next;
  logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
  logic            prev_ready_reg;
  logic            accept, ignored, is_e0, is_f0;
  logic            event_next, ext_next, brk_next;
  logic [6:0]      key_state_next;

  assign accept = ps2_ready && !prev_ready_reg;
  assign is_e0  = (ps2_data == 8'hE0);
  assign is_f0  = (ps2_data == 8'hF0);

  // Controller, ack, error and pause-prefix codes never form a key event.
  always_comb begin
    case (ps2_data)
      8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA,
      8'hFC, 8'hFD, 8'hFE, 8'hFF: ignored = 1'b1;
      default:                    ignored = 1'b0;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    to_cnt_next = '0;
    event_next  = 1'b0;
    ext_next    = (state_reg == S_E0) || (state_reg == S_E0F0);
    brk_next    = (state_reg == S_F0) || (state_reg == S_E0F0);
    if (accept) begin
      if (is_e0)
        state_next = brk_next ? S_E0F0 : S_E0;
      else if (is_f0)
        state_next = ext_next ? S_E0F0 : S_F0;
      else begin
        state_next = S_IDLE;
        event_next = !ignored;
      end
    end else if (state_reg != S_IDLE) begin
      // A pending prefix is dropped once it has waited PREFIX_TIMEOUT cycles.
      if (to_cnt_reg == TO_LAST)
        state_next = S_IDLE;
      else
        to_cnt_next = to_cnt_reg + 1'b1;
    end
  end

  always_comb begin
    key_state_next = key_state;
    if (event_next) begin
      case ({ext_next, ps2_data})
        {1'b1, 8'h6B}, {1'b0, 8'h1C}: key_state_next[0] = !brk_next;
        {1'b1, 8'h74}, {1'b0, 8'h23}: key_state_next[1] = !brk_next;
        {1'b1, 8'h75}, {1'b0, 8'h1D}: key_state_next[2] = !brk_next;
        {1'b1, 8'h72}, {1'b0, 8'h1B}: key_state_next[3] = !brk_next;
        {1'b0, 8'h29}:                key_state_next[4] = !brk_next;
        {1'b0, 8'h5A}:                key_state_next[5] = !brk_next;
        {1'b0, 8'h76}:                key_state_next[6] = !brk_next;
        default:                      key_state_next = key_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_ready_reg <= 1'b1;
      state_reg      <= S_IDLE;
      to_cnt_reg     <= '0;
      key_event      <= 1'b0;
      key_code       <= 8'h00;
      key_ext        <= 1'b0;
      key_break      <= 1'b0;
      key_state      <= '0;
    end else begin
      prev_ready_reg <= ps2_ready;
      state_reg      <= state_next;
      to_cnt_reg     <= to_cnt_next;
      key_event      <= event_next;
      if (event_next) begin
        key_code  <= ps2_data;
        key_ext   <= ext_next;
        key_break <= brk_next;
      end
      key_state <= key_state_next;
    end
  end

endmodule

// File: tb/tb_ps2_keydecode.sv
// Bench for ps2_keydecode: directed scenarios plus random byte streams
// compared against a prefix-flag / timestamp reference model.
module tb_ps2_keydecode;
  localparam int PT = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ps2_data;
  logic       ps2_ready;
  logic       key_event;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic [6:0] key_state;

  ps2_keydecode #(.PREFIX_TIMEOUT(PT), .TO_W(4)) dut (
    .clk(clk), .rst(rst), .ps2_data(ps2_data), .ps2_ready(ps2_ready),
    .key_event(key_event), .key_code(key_code), .key_ext(key_ext),
    .key_break(key_break), .key_state(key_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Reference model: pending prefix flags, time of the last accepted byte.
  bit         m_ext, m_brk, m_ext_o, m_brk_o;
  int         m_last;
  logic [6:0] m_keys;
  logic [7:0] m_code;

  bit         tab_ext  [11] = '{1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0};
  logic [7:0] tab_code [11] = '{8'h6B, 8'h1C, 8'h74, 8'h23, 8'h75, 8'h1D,
                                8'h72, 8'h1B, 8'h29, 8'h5A, 8'h76};
  int         tab_idx  [11] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 5, 6};
  logic [7:0] ign_list [9]  = '{8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA,
                                8'hFC, 8'hFD, 8'hFE, 8'hFF};

  // Observations from the latest send_byte and the model's expectation.
  bit         e_ev;
  logic       o_pulse, o_ext, o_brk;
  logic [7:0] o_code;
  logic [6:0] o_state;
  int         o_extra;

  function automatic bit is_ign(input logic [7:0] b);
    for (int i = 0; i < 9; i++) if (ign_list[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_ext_o = 0; m_brk_o = 0;
    m_keys = '0; m_code = 8'h00; m_last = 0;
  endtask

  task automatic model_accept(input logic [7:0] b, output bit ev);
    ev = 1'b0;
    if ((m_ext || m_brk) && (cyc - m_last > PT)) begin
      m_ext = 0; m_brk = 0;
    end
    m_last = cyc;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (!is_ign(b)) begin
        ev = 1'b1;
        m_code = b; m_ext_o = m_ext; m_brk_o = m_brk;
        for (int i = 0; i < 11; i++)
          if (tab_ext[i] == m_ext && tab_code[i] == b) m_keys[tab_idx[i]] = !m_brk;
      end
      m_ext = 0; m_brk = 0;
    end
  endtask

  // Raise ps2_ready with byte b for hold cycles, then drop it for gap cycles.
  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    @(negedge clk);
    ps2_data = b; ps2_ready = 1'b1;
    model_accept(b, e_ev);
    @(negedge clk);
    o_pulse = key_event; o_code = key_code; o_ext = key_ext;
    o_brk = key_break; o_state = key_state; o_extra = 0;
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      if (key_event) o_extra++;
    end
    ps2_ready = 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      if (key_event) o_extra++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ps2_ready = 1'b0; ps2_data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0; model_reset();
    @(negedge clk);
    checks++;
    if ({key_event, key_code, key_ext, key_break, key_state} !== 18'd0)
      $display("FAIL reset_outputs: got ev=%b code=%h ext=%b brk=%b st=%b, want all zero",
               key_event, key_code, key_ext, key_break, key_state);
    if ({key_event, key_code, key_ext, key_break, key_state} !== 18'd0) errors++;
  endtask

  task automatic test_make_break();
    send_byte(8'h29, 20, 2);
    checks++;
    if (o_pulse !== 1'b1 || o_extra != 0 || o_code !== 8'h29 || o_ext !== 1'b0 ||
        o_brk !== 1'b0 || o_state !== 7'b0010000) begin
      errors++;
      $display("FAIL make_29: got ev=%b extra=%0d code=%h ext=%b brk=%b st=%b, want 1 0 29 0 0 0010000",
               o_pulse, o_extra, o_code, o_ext, o_brk, o_state);
    end
    send_byte(8'h29, 3, 2);
    checks++;
    if (o_pulse !== 1'b1 || o_state !== 7'b0010000) begin
      errors++;
      $display("FAIL typematic_29: got ev=%b st=%b, want 1 0010000", o_pulse, o_state);
    end
    send_byte(8'hF0, 1, 1);
    checks++;
    if (o_pulse !== 1'b0 || o_extra != 0) begin
      errors++;
      $display("FAIL prefix_f0_quiet: got ev=%b extra=%0d, want 0 0", o_pulse, o_extra);
    end
    send_byte(8'h29, 2, 2);
    checks++;
    if (o_pulse !== 1'b1 || o_code !== 8'h29 || o_ext !== 1'b0 || o_brk !== 1'b1 ||
        o_state !== 7'b0000000) begin
      errors++;
      $display("FAIL break_29: got ev=%b code=%h ext=%b brk=%b st=%b, want 1 29 0 1 0000000",
               o_pulse, o_code, o_ext, o_brk, o_state);
    end
  endtask

  task automatic test_extended();
    send_byte(8'hE0, 1, 1);
    send_byte(8'h6B, 1, 1);
    checks++;
    if (o_pulse !== 1'b1 || o_code !== 8'h6B || o_ext !== 1'b1 || o_brk !== 1'b0 ||
        o_state !== 7'b0000001) begin
      errors++;
      $display("FAIL make_e0_6b: got ev=%b code=%h ext=%b brk=%b st=%b, want 1 6b 1 0 0000001",
               o_pulse, o_code, o_ext, o_brk, o_state);
    end
    send_byte(8'hE0, 1, 1);
    send_byte(8'hF0, 1, 1);
    checks++;
    if (o_pulse !== 1'b0 || o_state !== 7'b0000001) begin
      errors++;
      $display("FAIL prefix_e0f0_quiet: got ev=%b st=%b, want 0 0000001", o_pulse, o_state);
    end
    send_byte(8'h6B, 1, 1);
    checks++;
    if (o_pulse !== 1'b1 || o_ext !== 1'b1 || o_brk !== 1'b1 || o_state !== 7'b0000000) begin
      errors++;
      $display("FAIL break_e0_6b: got ev=%b ext=%b brk=%b st=%b, want 1 1 1 0000000",
               o_pulse, o_ext, o_brk, o_state);
    end
  endtask

  task automatic test_alias();
    send_byte(8'h1C, 1, 1);
    checks++;
    if (o_state[0] !== 1'b1) begin
      errors++; $display("FAIL alias_1c: got left=%b, want 1", o_state[0]);
    end
    send_byte(8'hE0, 1, 1); send_byte(8'h6B, 1, 1);
    checks++;
    if (o_state[0] !== 1'b1 || o_pulse !== 1'b1) begin
      errors++; $display("FAIL alias_e0_6b: got left=%b ev=%b, want 1 1", o_state[0], o_pulse);
    end
    send_byte(8'hE0, 1, 1); send_byte(8'hF0, 1, 1); send_byte(8'h6B, 1, 1);
    checks++;
    if (o_state[0] !== 1'b0) begin
      errors++; $display("FAIL alias_release: got left=%b, want 0", o_state[0]);
    end
    send_byte(8'h6B, 1, 1);
    checks++;
    if (o_pulse !== 1'b1 || o_ext !== 1'b0 || o_code !== 8'h6B || o_state !== 7'b0000000) begin
      errors++;
      $display("FAIL keypad4_ignored: got ev=%b ext=%b code=%h st=%b, want 1 0 6b 0000000",
               o_pulse, o_ext, o_code, o_state);
    end
    send_byte(8'hE0, 1, 1); send_byte(8'h1C, 1, 1);
    checks++;
    if (o_pulse !== 1'b1 || o_ext !== 1'b1 || o_state !== 7'b0000000) begin
      errors++;
      $display("FAIL e0_1c_ignored: got ev=%b ext=%b st=%b, want 1 1 0000000", o_pulse, o_ext, o_state);
    end
  endtask

  task automatic test_ignored();
    send_byte(8'hAA, 1, 1);
    checks++;
    if (o_pulse !== 1'b0 || o_extra != 0) begin
      errors++; $display("FAIL ignore_aa: got ev=%b extra=%0d, want 0 0", o_pulse, o_extra);
    end
    send_byte(8'hFA, 1, 1);
    checks++;
    if (o_pulse !== 1'b0 || o_code !== 8'h1C) begin
      errors++; $display("FAIL ignore_fa: got ev=%b code=%h, want 0 1c", o_pulse, o_code);
    end
    send_byte(8'hE0, 1, 1); send_byte(8'hFA, 1, 1);
    checks++;
    if (o_pulse !== 1'b0) begin
      errors++; $display("FAIL e0_fa: got ev=%b, want 0", o_pulse);
    end
    send_byte(8'h75, 1, 1);
    checks++;
    if (o_pulse !== 1'b1 || o_ext !== 1'b0 || o_code !== 8'h75 || o_state !== 7'b0000000) begin
      errors++;
      $display("FAIL after_fa_75: got ev=%b ext=%b code=%h st=%b, want 1 0 75 0000000",
               o_pulse, o_ext, o_code, o_state);
    end
  endtask

  task automatic test_timeout();
    // Accepted bytes are hold+gap+1 cycles apart: 9 cycles expires, 8 does not.
    send_byte(8'hF0, 1, PT - 1);
    send_byte(8'h29, 1, 1);
    checks++;
    if (o_pulse !== 1'b1 || o_brk !== 1'b0 || o_state !== 7'b0010000) begin
      errors++;
      $display("FAIL timeout_expired: got ev=%b brk=%b st=%b, want 1 0 0010000", o_pulse, o_brk, o_state);
    end
    send_byte(8'hF0, 1, PT - 2);
    send_byte(8'h29, 1, 1);
    checks++;
    if (o_pulse !== 1'b1 || o_brk !== 1'b1 || o_state !== 7'b0000000) begin
      errors++;
      $display("FAIL timeout_edge_kept: got ev=%b brk=%b st=%b, want 1 1 0000000", o_pulse, o_brk, o_state);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    send_byte(8'h1D, 1, 1);
    send_byte(8'hE0, 1, 1);
    send_byte(8'hF0, 1, 1);
    @(negedge clk);
    rst = 1'b1; ps2_data = 8'h29; ps2_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({key_event, key_code, key_ext, key_break, key_state} !== 18'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got ev=%b code=%h ext=%b brk=%b st=%b, want all zero",
               key_event, key_code, key_ext, key_break, key_state);
    end
    @(negedge clk);
    rst = 1'b0; model_reset();
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (key_event) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL ready_high_at_release: got %0d events, want 0", seen);
    end
    ps2_ready = 1'b0;
    send_byte(8'h74, 1, 1);
    checks++;
    if (o_pulse !== 1'b1 || o_code !== 8'h74 || o_ext !== 1'b0 || o_brk !== 1'b0 ||
        o_state !== 7'b0000000) begin
      errors++;
      $display("FAIL post_reset_74: got ev=%b code=%h ext=%b brk=%b st=%b, want 1 74 0 0 0000000",
               o_pulse, o_code, o_ext, o_brk, o_state);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    int r;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 2)      b = (r == 0) ? 8'hE0 : 8'hF0;
      else if (r == 3) b = ign_list[$urandom_range(0, 8)];
      else if (r <= 7) b = tab_code[$urandom_range(0, 10)];
      else             b = 8'($urandom_range(0, 255));
      send_byte(b, $urandom_range(1, 3), $urandom_range(0, 10));
      checks++;
      if (o_pulse !== e_ev || o_extra != 0 || o_code !== m_code || o_ext !== m_ext_o ||
          o_brk !== m_brk_o || o_state !== m_keys) begin
        errors++;
        $display("FAIL random_%0d byte=%h: got ev=%b extra=%0d code=%h ext=%b brk=%b st=%b, want ev=%b code=%h ext=%b brk=%b st=%b",
                 n, b, o_pulse, o_extra, o_code, o_ext, o_brk, o_state,
                 e_ev, m_code, m_ext_o, m_brk_o, m_keys);
      end
    end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_extended();
    test_alias();
    test_ignored();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_keydecode.md
# ps2_keydecode

Scan-code decoder sitting directly downstream of the PS/2 byte receiver. Consumes received Set-2 bytes, resolves `E0` (extended) and `F0` (break) prefixes, and emits one make/break event per key. Maintains a registered pressed-state bitmap of the game control keys for the game logic. Stale prefixes are abandoned after a configurable timeout.

## Interface
- `PREFIX_TIMEOUT`, default 100000: clock cycles a prefix may wait for its next byte (2 ms at 50 MHz); must be ≥ 2.
- `TO_W`, default 17: width of the timeout counter; must satisfy 2^TO_W > PREFIX_TIMEOUT.

Ports:
- `clk` input 1: system clock. One clock; every register is clocked on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `ps2_data` input 8: byte from the receiver; valid whenever `ps2_ready` is high.
- `ps2_ready` input 1: receiver byte-available level. It rises once per byte and may stay high for many cycles.
- `key_event` output 1: one-cycle pulse when a complete key code is decoded.
- `key_code` output 8: final (non-prefix) scan byte of the event; held until the next event.
- `key_ext` output 1: event carried an `E0` prefix; held.
- `key_break` output 1: event was a release (carried `F0`); held.
- `key_state` output 7: pressed flags, as follows.
  - [0] left: `E0 6B` or `1C`
  - [1] right: `E0 74` or `23`
  - [2] up: `E0 75` or `1D`
  - [3] down: `E0 72` or `1B`
  - [4] jump: `29`
  - [5] start: `5A`
  - [6] pause: `76`

## Operation
- Byte acceptance:
  - `prev_ready` is registered every cycle.
  - A byte is accepted in cycle N when `ps2_ready`=1 and `prev_ready`=0. `ps2_data` is sampled in that same cycle.
  - Exactly one acceptance per rising edge of `ps2_ready`, however long it stays high.
- FSM states: IDLE, E0, F0, E0F0. Transitions on an accepted byte:
  - IDLE: `E0`→E0; `F0`→F0; ignored byte→IDLE, no event; other byte→event (ext=0, brk=0), →IDLE.
  - E0: `E0`→E0; `F0`→E0F0; ignored→IDLE, no event; other→event (ext=1, brk=0), →IDLE.
  - F0: `F0`→F0; `E0`→E0F0; ignored→IDLE, no event; other→event (ext=0, brk=1), →IDLE.
  - E0F0: `E0` or `F0`→E0F0; ignored→IDLE, no event; other→event (ext=1, brk=1), →IDLE.
- Ignored bytes: `00`, `AA`, `E1`, `EE`, `FA`, `FC`, `FD`, `FE`, `FF` (controller/ack/error/pause-prefix codes).
- Timeout:
  - The counter clears on every accepted byte and in IDLE.
  - In any prefix state it increments each cycle without acceptance.
  - When it reaches PREFIX_TIMEOUT−1, the next cycle forces IDLE with no event.
  - If acceptance and expiry fall in the same cycle, acceptance wins.
- key_state update, on each event:
  - If the (ext, code) pair matches a row of the table, that bit is set to !brk. Non-matching events leave key_state unchanged.
  - Aliased keys (arrow and WASD) share one bit: the last event wins. Releasing either alias clears the bit.
  - A make for an already-set bit (typematic repeat) still pulses `key_event`; the bit stays 1.
  - Wrong extension flag does not match: `6B` without E0 is keypad-4 and is ignored; `E0 1C` is ignored.

## Timing
- Byte accepted in cycle N → `key_event`=1 in cycle N+1 only. `key_code`, `key_ext`, `key_break` and `key_state` take their new values in N+1.
- Minimum spacing between events is 2 cycles, given the edge detect. No backpressure: the receiver cannot be stalled, and the decoder accepts every byte.
- Reset values:
  - `key_event`=0, `key_code`=00, `key_ext`=0, `key_break`=0, `key_state`=0.
  - FSM in IDLE, timeout counter 0.
  - `prev_ready`=1, so a `ps2_ready` already high when reset releases is not accepted.
- Reset asserted mid-sequence (e.g. after `E0 F0`) discards the prefix. The next byte is decoded from IDLE.
- Reset asserted in the same cycle as an acceptance: reset wins, no event.

## Test plan
- Drive `ps2_ready` 0→1 (held 20 cycles) with `29`, then 0 → a single `key_event` 1 cycle after the edge; code=29, ext=0, brk=0; key_state=0010000. Then `F0`,`29` → one event, brk=1; key_state=0.
- `E0`,`6B` → event ext=1, code=6B, key_state[0]=1. Then `E0`,`F0`,`6B` → event ext=1, brk=1, key_state[0]=0. Prefix bytes alone produce no `key_event`.
- Alias: `1C` then `E0 6B` then `E0 F0 6B` → key_state[0] goes 1,1,0. Then `6B` (no E0) → event pulses, key_state unchanged.
- Ignored and special bytes:
  - `AA` and `FA` from IDLE → no event, state IDLE.
  - `E0` then `FA` → no event, back to IDLE; next `75` decodes with ext=0.
- Timeout with PREFIX_TIMEOUT=8:
  - `F0`, then 8 idle cycles, then `29` → make event (brk=0).
  - Repeat with the byte arriving at idle cycle 7 → break event.
- Reset:
  - Assert `rst` one cycle after `E0 F0` → outputs zero.
  - Release with `ps2_ready` held high → no event until the next rising edge.
  - Then `74` → ext=0 event, key_state unchanged.
